// File: rtl/cia_tod.sv
// rtl/cia_tod.sv - CIA time-of-day clock: BCD counter, alarm, read latch and alarm strobe
//
// Ports:
//   clk        system clock, one register cycle per clk
//   res_n      asynchronous active-low reset
//   tod        raw 50/60 Hz TOD pin, asynchronous to clk
//   todin      1 = 50 Hz (divide by 5), 0 = 60 Hz (divide by 6)
//   alarm_sel  1 = writes target the alarm registers
//   we, re     one-cycle write/read strobes for the TOD register at addr
//   addr       0 = 10ths, 1 = sec, 2 = min, 3 = hr
//   data_i     write data
//   data_o     read data, combinational from addr (qualify with re)
//   irq_alarm  one-cycle alarm pulse to the ICR
//   running    1 while the counter is not stopped
module cia_tod #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       tod,
    input  logic       todin,
    input  logic       alarm_sel,
    input  logic       we,
    input  logic       re,
    input  logic [1:0] addr,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       irq_alarm,
    output logic       running
);

    // BCD low digit step: returns {carry, next}. Digits above 9 count in
    // binary (F wraps to 0) without carrying so they drift back into range.
    function automatic logic [4:0] inc_lo(input logic [3:0] d);
        if (d == 4'd9) return {1'b1, 4'd0};
        else           return {1'b0, d + 4'd1};
    endfunction

    // Tens digit of sec/min: 0..5; 6 and 7 step without carry.
    function automatic logic [3:0] inc_hi(input logic [2:0] d);
        if (d == 3'd5) return {1'b1, 3'd0};
        else           return {1'b0, d + 3'd1};
    endfunction

    // Hour step on the packed {pm, tens, ones} form: 12 -> 01, 11 -> 12 flips pm.
    function automatic logic [5:0] inc_hr(input logic [5:0] h);
        if (h[4:0] == 5'h12)      return {h[5], 5'h01};
        else if (h[4:0] == 5'h11) return {~h[5], 5'h12};
        else if (h[3:0] == 4'h9)  return {h[5], 5'h10};
        else                      return {h[5], h[4], h[3:0] + 4'd1};
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic [2:0]             presc_q, presc_d;
    logic                   stopped_q, stopped_d;
    logic [3:0]             tenths_q, tenths_d;
    logic [6:0]             sec_q, sec_d;
    logic [6:0]             min_q, min_d;
    logic [5:0]             hr_q, hr_d;          // {pm, tens, ones[3:0]}
    logic [3:0]             al_t_q, al_t_d;
    logic [6:0]             al_s_q, al_s_d;
    logic [6:0]             al_m_q, al_m_d;
    logic [5:0]             al_h_q, al_h_d;
    logic [7:0]             lat_q [4];
    logic [7:0]             lat_d [4];
    logic                   latched_q, latched_d;
    logic                   match_q;
    logic                   irq_q;

    logic       synced, tick, tenth, time_we, match;
    logic [2:0] wrap;
    logic [7:0] live [4];
    logic [4:0] t_inc, sl_inc, ml_inc;
    logic [3:0] sh_inc, mh_inc;
    logic       c_t, c_sl, c_sh, c_ml, c_mh;

    assign synced = sync_q[SYNC_STAGES-1];
    assign tick   = synced & ~edge_q;
    assign wrap   = todin ? 3'd4 : 3'd5;
    assign time_we = we & ~alarm_sel;

    assign live[0] = {4'b0, tenths_q};
    assign live[1] = {1'b0, sec_q};
    assign live[2] = {1'b0, min_q};
    assign live[3] = {hr_q[5], 2'b0, hr_q[4:0]};

    assign data_o    = latched_q ? lat_q[addr] : live[addr];
    assign irq_alarm = irq_q;
    assign running   = ~stopped_q;

    assign match = (tenths_q == al_t_q) && (sec_q == al_s_q) &&
                   (min_q == al_m_q) && (hr_q == al_h_q);

    // Carry chain; each digit only moves when everything below it wraps.
    assign t_inc  = inc_lo(tenths_q);
    assign sl_inc = inc_lo(sec_q[3:0]);
    assign sh_inc = inc_hi(sec_q[6:4]);
    assign ml_inc = inc_lo(min_q[3:0]);
    assign mh_inc = inc_hi(min_q[6:4]);
    assign c_t  = t_inc[4];
    assign c_sl = c_t & sl_inc[4];
    assign c_sh = c_sl & sh_inc[3];
    assign c_ml = c_sh & ml_inc[4];
    assign c_mh = c_ml & mh_inc[3];

    always_comb begin
        presc_d   = presc_q;
        stopped_d = stopped_q;
        tenth     = 1'b0;
        if (stopped_q) begin
            presc_d = 3'd0;
        end else if (tick) begin
            // >= so a todin change that leaves us past the new wrap recovers next tick
            if (presc_q >= wrap) begin
                presc_d = 3'd0;
                tenth   = 1'b1;
            end else begin
                presc_d = presc_q + 3'd1;
            end
        end
        if (time_we && addr == 2'd0) begin
            presc_d   = 3'd0;
            stopped_d = 1'b0;
        end
        if (time_we && addr == 2'd3) begin
            stopped_d = 1'b1;
        end
    end

    always_comb begin
        tenths_d = tenths_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hr_d     = hr_q;
        // A time write swallows the whole increment of that cycle.
        if (time_we) begin
            case (addr)
                2'd0:    tenths_d = data_i[3:0];
                2'd1:    sec_d    = data_i[6:0];
                2'd2:    min_d    = data_i[6:0];
                default: hr_d     = {data_i[7], data_i[4:0]};
            endcase
        end else if (tenth) begin
            tenths_d = t_inc[3:0];
            if (c_t)  sec_d[3:0] = sl_inc[3:0];
            if (c_sl) sec_d[6:4] = sh_inc[2:0];
            if (c_sh) min_d[3:0] = ml_inc[3:0];
            if (c_ml) min_d[6:4] = mh_inc[2:0];
            if (c_mh) hr_d       = inc_hr(hr_q);
        end
    end

    always_comb begin
        al_t_d = al_t_q;
        al_s_d = al_s_q;
        al_m_d = al_m_q;
        al_h_d = al_h_q;
        if (we && alarm_sel) begin
            case (addr)
                2'd0:    al_t_d = data_i[3:0];
                2'd1:    al_s_d = data_i[6:0];
                2'd2:    al_m_d = data_i[6:0];
                default: al_h_d = {data_i[7], data_i[4:0]};
            endcase
        end
    end

    always_comb begin
        latched_d = latched_q;
        for (int i = 0; i < 4; i++) lat_d[i] = lat_q[i];
        if (re && addr == 2'd3 && !latched_q) begin
            for (int i = 0; i < 4; i++) lat_d[i] = live[i];
            latched_d = 1'b1;
        end else if (re && addr == 2'd0) begin
            latched_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync_q    <= '0;
            edge_q    <= 1'b0;
            presc_q   <= 3'd0;
            stopped_q <= 1'b1;
            tenths_q  <= 4'd0;
            sec_q     <= 7'd0;
            min_q     <= 7'd0;
            hr_q      <= 6'h01;
            al_t_q    <= 4'd0;
            al_s_q    <= 7'd0;
            al_m_q    <= 7'd0;
            al_h_q    <= 6'd0;
            for (int i = 0; i < 4; i++) lat_q[i] <= 8'd0;
            latched_q <= 1'b0;
            match_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], tod};
            edge_q    <= synced;
            presc_q   <= presc_d;
            stopped_q <= stopped_d;
            tenths_q  <= tenths_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hr_q      <= hr_d;
            al_t_q    <= al_t_d;
            al_s_q    <= al_s_d;
            al_m_q    <= al_m_d;
            al_h_q    <= al_h_d;
            for (int i = 0; i < 4; i++) lat_q[i] <= lat_d[i];
            latched_q <= latched_d;
            match_q   <= match;
            irq_q     <= match & ~match_q;
        end
    end

endmodule
